// File: rtl/soc2_sysid_pkg.sv
// Shared types and constants for the SoC2 system-ID checker and its helpers.
package soc2_sysid_pkg;

    localparam int unsigned SYSID_DATA_W  = 32;
    localparam int unsigned SYSID_TIMER_W = 16;

    // Word addresses inside the SYSID control slave
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Default build-time expectations
    localparam logic [SYSID_DATA_W-1:0] SYSID_DEF_EXPECTED_ID = 32'd0;
    localparam logic [SYSID_DATA_W-1:0] SYSID_DEF_EXPECTED_TS = 32'd1730382246;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_FIN   = 2'd3
    } sysid_state_e;

endpackage

// File: rtl/soc2_stall_timer.sv
// Loadable stall counter for Avalon masters: counts stalled cycles and raises a
// sticky expired flag once MAX_COUNT stalls have been seen since the last load.
module soc2_stall_timer #(
    parameter int unsigned MAX_COUNT = 255,
    parameter int unsigned CNT_W     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    // Next count: load restarts from zero, increments stop once expired
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (inc_i && !expired_q) begin
            count_d = count_q + CNT_W'(1);
        end
        expired_d = (count_d == CNT_W'(MAX_COUNT));
    end

    // Counter and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/soc2_sysid_checker.sv
// Avalon-MM read initiator that fetches the system-ID and build-timestamp
// words from the SYSID responder and reports whether they match this build.
module soc2_sysid_checker
    import soc2_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEF_EXPECTED_TS,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_state_e state_q, state_d;

    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic tmr_load, tmr_inc, tmr_expired;

    // Per-read stall watchdog
    soc2_stall_timer #(
        .MAX_COUNT (TIMEOUT_CYCLES),
        .CNT_W     (SYSID_TIMER_W)
    ) u_stall_timer (
        .clk       (clock),
        .rst_n     (reset_n),
        .load_i    (tmr_load),
        .inc_i     (tmr_inc),
        .expired_o (tmr_expired)
    );

    // Next-state and next-output logic; bus outputs only change on acceptance
    // or abort so address/read stay stable while the responder stalls
    always_comb begin
        state_d    = state_q;
        read_d     = read_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        tmr_load   = 1'b0;
        tmr_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pass_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                    tmr_load  = 1'b1;
                    read_d    = 1'b1;
                    addr_d    = SYSID_ADDR_ID;
                    busy_d    = 1'b1;
                    state_d   = ST_RD_ID;
                end
            end

            ST_RD_ID: begin
                if (!avm_waitrequest) begin
                    id_value_d = avm_readdata;
                    id_ok_d    = (avm_readdata == EXPECTED_ID);
                    tmr_load   = 1'b1;
                    addr_d     = SYSID_ADDR_TS;
                    state_d    = ST_RD_TS;
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    read_d    = 1'b0;
                    addr_d    = SYSID_ADDR_ID;
                    done_d    = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            ST_RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_value_d = avm_readdata;
                    ts_ok_d    = (avm_readdata == EXPECTED_TS);
                    read_d     = 1'b0;
                    addr_d     = SYSID_ADDR_ID;
                    done_d     = 1'b1;
                    state_d    = ST_FIN;
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    read_d    = 1'b0;
                    addr_d    = SYSID_ADDR_ID;
                    done_d    = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                read_d  = 1'b0;
                addr_d  = SYSID_ADDR_ID;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Verdict is latched on the way into FIN so it lines up with done
        if (done_d) begin
            pass_d = id_ok_d & (ts_ok_d | ~CHECK_TS) & ~timeout_d;
        end
    end

    // State and output registers; reset drops the read strobe immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            read_q     <= 1'b0;
            addr_q     <= SYSID_ADDR_ID;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_soc2_sysid_checker.sv
// Directed bench for soc2_sysid_checker: normal check, timestamp mismatch with
// and without CHECK_TS, stalled reads, stall timeout, restart-while-busy and
// reset in the middle of a read.
module tb_soc2_sysid_checker;

    localparam logic [31:0] GOOD_TS = 32'd1730382246;
    localparam logic [31:0] BAD_TS  = 32'h12345678;

    logic clock;
    logic reset_n;
    logic start;
    logic start_c;
    logic wait_c;

    // Responder model shared by dut_a and dut_b
    int          stall_n;
    int          stall_cnt;
    logic [31:0] rsp_id;
    logic [31:0] rsp_ts;
    logic        waitreq;
    logic [31:0] rdata;

    // dut_a: CHECK_TS=1, default timeout
    logic        a_addr, a_read, a_busy, a_done, a_pass, a_id_ok, a_ts_ok, a_to;
    logic [31:0] a_idv, a_tsv;
    // dut_b: CHECK_TS=0, same bus stimulus as dut_a
    logic        b_addr, b_read, b_busy, b_done, b_pass, b_id_ok, b_ts_ok, b_to;
    logic [31:0] b_idv, b_tsv;
    // dut_c: TIMEOUT_CYCLES=4, own stall input
    logic        c_addr, c_read, c_busy, c_done, c_pass, c_id_ok, c_ts_ok, c_to;
    logic [31:0] c_idv, c_tsv;

    int n_cmp;
    int n_err;
    int done_cnt;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign waitreq = a_read && (stall_cnt < stall_n);
    assign rdata   = a_addr ? rsp_ts : rsp_id;

    // Counts stalled cycles of the current read; restarts on acceptance
    always @(posedge clock) begin
        if (a_read && waitreq) stall_cnt <= stall_cnt + 1;
        else                   stall_cnt <= 0;
    end

    soc2_sysid_checker dut_a (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(a_addr), .avm_read(a_read),
        .avm_readdata(rdata), .avm_waitrequest(waitreq),
        .busy(a_busy), .done(a_done), .pass(a_pass), .id_ok(a_id_ok),
        .ts_ok(a_ts_ok), .timeout(a_to), .id_value(a_idv), .ts_value(a_tsv)
    );

    soc2_sysid_checker #(.CHECK_TS(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(b_addr), .avm_read(b_read),
        .avm_readdata(rdata), .avm_waitrequest(waitreq),
        .busy(b_busy), .done(b_done), .pass(b_pass), .id_ok(b_id_ok),
        .ts_ok(b_ts_ok), .timeout(b_to), .id_value(b_idv), .ts_value(b_tsv)
    );

    soc2_sysid_checker #(.TIMEOUT_CYCLES(4)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(start_c),
        .avm_address(c_addr), .avm_read(c_read),
        .avm_readdata(32'h0), .avm_waitrequest(wait_c),
        .busy(c_busy), .done(c_done), .pass(c_pass), .id_ok(c_id_ok),
        .ts_ok(c_ts_ok), .timeout(c_to), .id_value(c_idv), .ts_value(c_tsv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise start before edge 0; returns in cycle 1 with start low again
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        start_c  = 1'b0;
        wait_c   = 1'b0;
        stall_n  = 0;
        rsp_id   = 32'd0;
        rsp_ts   = GOOD_TS;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_read",  32'(a_read), 32'd0);
        chk("rst_addr",  32'(a_addr), 32'd0);
        chk("rst_busy",  32'(a_busy), 32'd0);
        chk("rst_done",  32'(a_done), 32'd0);
        chk("rst_pass",  32'(a_pass), 32'd0);
        chk("rst_to",    32'(a_to),   32'd0);
        chk("rst_tsv",   a_tsv,       32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Zero-wait responder, matching words
        pulse_start();
        chk("t1_c1_read", 32'(a_read), 32'd1);
        chk("t1_c1_addr", 32'(a_addr), 32'd0);
        chk("t1_c1_busy", 32'(a_busy), 32'd1);
        chk("t1_c1_done", 32'(a_done), 32'd0);
        @(negedge clock);
        chk("t1_c2_read", 32'(a_read), 32'd1);
        chk("t1_c2_addr", 32'(a_addr), 32'd1);
        @(negedge clock);
        chk("t1_c3_done",  32'(a_done),  32'd1);
        chk("t1_c3_pass",  32'(a_pass),  32'd1);
        chk("t1_c3_idok",  32'(a_id_ok), 32'd1);
        chk("t1_c3_tsok",  32'(a_ts_ok), 32'd1);
        chk("t1_c3_idv",   a_idv,        32'd0);
        chk("t1_c3_tsv",   a_tsv,        GOOD_TS);
        chk("t1_c3_read",  32'(a_read),  32'd0);
        @(negedge clock);
        chk("t1_c4_done",  32'(a_done),  32'd0);
        chk("t1_c4_busy",  32'(a_busy),  32'd0);
        chk("t1_c4_pass",  32'(a_pass),  32'd1);

        // Timestamp mismatch: fails with CHECK_TS=1, passes with CHECK_TS=0
        rsp_ts = BAD_TS;
        pulse_start();
        @(negedge clock);
        @(negedge clock);
        chk("t2_a_done", 32'(a_done),  32'd1);
        chk("t2_a_pass", 32'(a_pass),  32'd0);
        chk("t2_a_tsok", 32'(a_ts_ok), 32'd0);
        chk("t2_a_idok", 32'(a_id_ok), 32'd1);
        chk("t2_a_tsv",  a_tsv,        BAD_TS);
        chk("t2_b_pass", 32'(b_pass),  32'd1);
        chk("t2_b_tsok", 32'(b_ts_ok), 32'd0);
        @(negedge clock);

        // Three stall cycles on each read: done in cycle 9, bus held steady
        rsp_ts  = GOOD_TS;
        stall_n = 3;
        pulse_start();
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("t3_c%0d_read", c), 32'(a_read), 32'd1);
            chk($sformatf("t3_c%0d_addr", c), 32'(a_addr), (c <= 4) ? 32'd0 : 32'd1);
            chk($sformatf("t3_c%0d_done", c), 32'(a_done), 32'd0);
            @(negedge clock);
        end
        chk("t3_c9_done", 32'(a_done), 32'd1);
        chk("t3_c9_pass", 32'(a_pass), 32'd1);
        chk("t3_c9_to",   32'(a_to),   32'd0);
        @(negedge clock);
        chk("t3_c10_done", 32'(a_done), 32'd0);
        stall_n = 0;

        // Stuck responder, TIMEOUT_CYCLES=4: done 5 cycles after entering RD_ID
        wait_c  = 1'b1;
        start_c = 1'b1;
        @(negedge clock);
        start_c = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("t4_c%0d_read", c), 32'(c_read), 32'd1);
            chk($sformatf("t4_c%0d_done", c), 32'(c_done), 32'd0);
            @(negedge clock);
        end
        chk("t4_c6_done", 32'(c_done), 32'd1);
        chk("t4_c6_to",   32'(c_to),   32'd1);
        chk("t4_c6_pass", 32'(c_pass), 32'd0);
        chk("t4_c6_read", 32'(c_read), 32'd0);
        @(negedge clock);
        chk("t4_c7_read", 32'(c_read), 32'd0);
        chk("t4_c7_done", 32'(c_done), 32'd0);
        chk("t4_c7_busy", 32'(c_busy), 32'd0);
        chk("t4_c7_to",   32'(c_to),   32'd1);
        wait_c = 1'b0;

        // start during RD_TS is ignored: exactly one done pulse
        pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_done) done_cnt++;
            @(negedge clock);
        end
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_busy",     32'(a_busy),   32'd0);
        chk("t5_pass",     32'(a_pass),   32'd1);

        // Reset asserted during RD_ID: outputs clear at once, no done
        stall_n = 1000;
        pulse_start();
        @(negedge clock);
        chk("t6_pre_read", 32'(a_read), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_read", 32'(a_read), 32'd0);
        chk("t6_busy", 32'(a_busy), 32'd0);
        chk("t6_done", 32'(a_done), 32'd0);
        chk("t6_tsv",  a_tsv,       32'd0);
        chk("t6_addr", 32'(a_addr), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        stall_n = 0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_done) done_cnt++;
            @(negedge clock);
        end
        chk("t6_done_cnt", 32'(done_cnt), 32'd0);
        chk("t6_post_busy", 32'(a_busy),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/soc2_sysid_checker.md
# soc2_sysid_checker

Avalon-MM read initiator that pairs with the SoC2 system-ID responder. On a start pulse it reads word 0 (system ID) and word 1 (build timestamp), compares both against build-time expected values, and reports pass/fail, so boot logic or a debug LED can confirm that software and FPGA image match. It sits on the SoC2 interconnect as a master aimed at the SYSID control slave; it drives only `address` and `read`.

## Interface
- EXPECTED_ID, 32'd0, expected system-ID word (address 0)
- EXPECTED_TS, 32'd1730382246, expected timestamp word (address 1)
- CHECK_TS, 1, 1 = timestamp mismatch fails the check; 0 = timestamp captured but ignored for `pass`
- TIMEOUT_CYCLES, 255, max cycles `avm_waitrequest` may stay high per read (1..65535)

- clock  in  1  system clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run a check
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  read strobe
- avm_readdata  in  32  responder data, valid in the cycle `avm_waitrequest` is low
- avm_waitrequest  in  1  responder stall
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check completes or aborts
- pass  out  1  last check passed (held)
- id_ok  out  1  last ID compare matched (held)
- ts_ok  out  1  last timestamp compare matched (held)
- timeout  out  1  last check aborted on stall (held)
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

## Operation
- Reset values: all outputs 0; avm_address 0; state IDLE; timer 0.
- States: IDLE, RD_ID, RD_TS, FIN.
- IDLE: `start`=1 → clear pass/id_ok/ts_ok/timeout, load timer, go RD_ID. Otherwise hold results.
- RD_ID: avm_read=1, avm_address=0. If avm_waitrequest=0: capture readdata into id_value, id_ok = (readdata==EXPECTED_ID), reload timer, go RD_TS.
- RD_TS: avm_read=1, avm_address=1. If avm_waitrequest=0: capture into ts_value, ts_ok = (readdata==EXPECTED_TS), go FIN.
- Stall: each cycle in RD_ID/RD_TS with waitrequest=1 increments timer; at TIMEOUT_CYCLES stalled cycles, drop avm_read, set timeout=1, skip remaining reads, go FIN.
- FIN: done=1 for exactly one cycle; pass = id_ok & (ts_ok | !CHECK_TS) & !timeout; go IDLE.
- busy=1 in RD_ID, RD_TS, FIN.
- `start` while busy is ignored (not queued).
- avm_address and avm_read are held stable while waitrequest=1 (Avalon master rule).
- Reset mid-read: avm_read drops asynchronously; results cleared; no done pulse.

## Timing
- Zero-wait responder: start sampled at edge 0; RD_ID during cycle 1, RD_TS cycle 2, done high cycle 3; pass/id_ok/ts_ok valid from cycle 3 and held.
- Each waitrequest cycle adds one cycle of latency.
- Timeout: done asserts TIMEOUT_CYCLES+1 cycles after entering the stalled read state.
- Outputs all registered; no combinational path from avm_readdata to any output.

## Structure
- Package `soc2_sysid_pkg`: state enum, address constants SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1, default expected-value constants.
- One sub-module: `soc2_stall_timer` (loadable counter, saturating flag at TIMEOUT_CYCLES), reusable by other SoC2 masters.

## Test plan
- Zero-wait responder returning 0 / 1730382246, start pulse → done at cycle 3, pass=1, id_ok=1, ts_ok=1, id_value=0, ts_value=1730382246.
- Responder returns ts=0x12345678, CHECK_TS=1 → pass=0, ts_ok=0, id_ok=1; with CHECK_TS=0 → pass=1.
- waitrequest high 3 cycles on each read → done at cycle 9, pass=1, address/read stable throughout stall.
- waitrequest stuck high, TIMEOUT_CYCLES=4 → done 5 cycles after entering RD_ID, timeout=1, pass=0, avm_read low afterwards.
- start pulsed again during RD_TS → ignored, single done pulse; reset_n low during RD_ID → all outputs 0 immediately, no done.
